tdoa_capture_sequencer: RTL
===========================

# tdoa_capture_sequencer

Sequencer in front of the TDOA datapath. It arms the hydrophone channels for one ping and timestamps each channel's first arrival relative to the earliest arrival. It presents the complete timestamp set to the TDOA calculation stage through a valid/ready handshake, then enforces a hold-off before returning to idle. Arrival strobes come from the per-channel threshold detectors and are already synchronous to `clk`.

## Interface
- `N_CH`, 4: number of hydrophone channels.
- `TS_W`, 24: timestamp width. Must satisfy 2^TS_W > TIMEOUT_CYC.
- `TIMEOUT_CYC`, 65536: capture window in cycles, measured from the first arrival.
- `HOLDOFF_CYC`, 1024: dead time after a handshake. 0 means none.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `arm`  in  1  start one capture. Sampled only in IDLE.
- `abort`  in  1  synchronous return to IDLE from any state.
- `trig`  in  N_CH  per-channel arrival strobes, level or pulse.
- `ts_data`  out  N_CH*TS_W  timestamps. Channel i occupies bits [i*TS_W +: TS_W].
- `ch_mask`  out  N_CH  bit i set means channel i was captured.
- `timeout`  out  1  window expired before all channels were captured.
- `ts_valid`  out  1  result available.
- `ts_ready`  in  1  downstream accepts the result.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, WAIT_FIRST, CAPTURE, PRESENT, HOLDOFF.
- IDLE: when `arm`=1, clear `ch_mask`, `timeout` and all `ts_data` fields to all-ones, then go to WAIT_FIRST.
- WAIT_FIRST: on the first edge where `trig`≠0 (call it edge t0):
  - every channel high at t0 gets ts=0 and its mask bit set;
  - the internal counter loads 1.
  - Next state is PRESENT if all channels were captured, otherwise CAPTURE.
  - There is no timeout in WAIT_FIRST; it waits indefinitely.
- CAPTURE, at edge t0+k with k=1..TIMEOUT_CYC-1: every uncaptured channel whose `trig` is high gets ts=k and its mask bit set. Already-captured channels ignore `trig`. The counter increments.
- All channels captured → PRESENT, `timeout`=0.
- At edge k=TIMEOUT_CYC-1, if channels are still missing after that edge's captures → PRESENT, `timeout`=1. Missing channels keep ts=all-ones and mask bit 0.
- Simultaneous event: if the last missing channel fires on the timeout edge, the capture wins and `timeout`=0.
- PRESENT: `ts_valid`=1. `ts_data`, `ch_mask` and `timeout` are held stable until handshake (`ts_valid`&`ts_ready` at an edge). After handshake, go to HOLDOFF, or to IDLE if HOLDOFF_CYC=0.
- HOLDOFF: count HOLDOFF_CYC cycles, then go to IDLE. `trig` and `arm` are ignored.
- `arm` outside IDLE is ignored. `trig` in IDLE, PRESENT and HOLDOFF is ignored.
- `abort`: any state → IDLE on the next edge and `ts_valid` goes to 0. Result registers keep their last values. `abort` has priority over every other transition, including a handshake on the same edge.
- Counter never wraps. Its maximum value is TIMEOUT_CYC-1.

## Timing
- Reset values: `ts_valid`=0, `busy`=0, `timeout`=0, `ch_mask`=0, `ts_data`=0; state=IDLE, counter=0.
- Reset assertion mid-operation clears everything immediately, without waiting for a clock edge.
- `arm` at edge e → `busy`=1 after edge e.
- Final capture (or timeout) at edge e → `ts_valid`=1 after edge e. Zero added latency.
- Handshake at edge h → `ts_valid`=0 after h. `busy` stays 1 through HOLDOFF_CYC further edges, then drops.
- Throughput: one result per ping. Minimum spacing between results is capture time + 1 (handshake) + HOLDOFF_CYC + 1 (arm) cycles.
- All outputs are registered.

## Test plan
Configuration for all scenarios: N_CH=4, TS_W=24, TIMEOUT_CYC=100, HOLDOFF_CYC=8.

1. Staggered arrivals:
   - stimulus: arm; ch2 at t0; ch0 and ch3 at t0+3; ch1 at t0+7;
   - response: ts {ch0=3, ch1=7, ch2=0, ch3=3}, `ch_mask`=4'b1111, `timeout`=0, `ts_valid` high right after edge t0+7.
2. Partial capture:
   - stimulus: only ch0 (t0) and ch1 (t0+5) fire;
   - response: `ts_valid` after edge t0+99, `ch_mask`=4'b0011, `timeout`=1, ch2/ch3 ts=24'hFFFFFF.
3. Last channel on the timeout edge:
   - stimulus: ch0–ch2 at t0, ch3 at t0+99;
   - response: ch3 ts=99, `ch_mask`=4'b1111, `timeout`=0.
4. Simultaneous arrivals:
   - stimulus: all four `trig` high at t0;
   - response: all ts=0; PRESENT entered directly from WAIT_FIRST; `ts_valid` after edge t0.
5. Backpressure and hold-off:
   - stimulus: hold `ts_ready`=0 for 20 cycles while toggling `trig` and `arm`, then raise `ts_ready`, and pulse `arm` during HOLDOFF;
   - response: outputs stay stable while `ts_ready`=0; `ts_valid` drops after the handshake; `busy` stays high for exactly 8 more cycles; the `arm` pulse in HOLDOFF is ignored.
6. Reset and abort:
   - stimulus: `rst_n` low mid-CAPTURE at k=40; separately, `abort` together with `ts_ready` while in PRESENT;
   - response: after `rst_n` low, all outputs are 0 immediately; after the `abort` edge, `ts_valid`=0, state=IDLE, and no HOLDOFF is entered.

Source files
------------

// File: rtl/tdoa_capture_sequencer.sv
// Arms the hydrophone channels for one ping, timestamps each channel's first
// arrival relative to the earliest one, presents the set via valid/ready, then holds off.
module tdoa_capture_sequencer #(
  parameter int N_CH        = 4,
  parameter int TS_W        = 24,
  parameter int TIMEOUT_CYC = 65536,
  parameter int HOLDOFF_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [N_CH-1:0]      trig,
  output logic [N_CH*TS_W-1:0] ts_data,
  output logic [N_CH-1:0]      ch_mask,
  output logic                 timeout,
  output logic                 ts_valid,
  input  logic                 ts_ready,
  output logic                 busy
);

  localparam int HW = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [TS_W-1:0] CNT_MAX  = TS_W'(TIMEOUT_CYC - 1);
  localparam logic [HW-1:0]   HOLD_MAX = (HOLDOFF_CYC > 0) ? HW'(HOLDOFF_CYC - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_FIRST, S_CAPTURE, S_PRESENT, S_HOLDOFF
  } state_t;

  state_t                state_q, state_d;
  logic [TS_W-1:0]       cnt_q, cnt_d;
  logic [HW-1:0]         hcnt_q, hcnt_d;
  logic [N_CH*TS_W-1:0]  ts_q, ts_d;
  logic [N_CH-1:0]       mask_q, mask_d;
  logic                  timeout_q, timeout_d;
  logic                  ts_valid_q, busy_q;
  logic [N_CH-1:0]       new_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      ts_q       <= '0;
      mask_q     <= '0;
      timeout_q  <= 1'b0;
      ts_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      ts_q       <= ts_d;
      mask_q     <= mask_d;
      timeout_q  <= timeout_d;
      // Status flags are decoded from the next state so they change on the same edge as the FSM.
      ts_valid_q <= (state_d == S_PRESENT);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    ts_d      = ts_q;
    mask_d    = mask_q;
    timeout_d = timeout_q;
    new_mask  = mask_q | trig;
    // Abort leaves the result registers untouched, so it bypasses every other update.
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            ts_d      = '1;
            mask_d    = '0;
            timeout_d = 1'b0;
            cnt_d     = '0;
            state_d   = S_WAIT_FIRST;
          end
        end
        S_WAIT_FIRST: begin
          if (|trig) begin
            for (int i = 0; i < N_CH; i++) begin
              if (trig[i]) ts_d[i*TS_W +: TS_W] = '0;
            end
            mask_d  = trig;
            cnt_d   = TS_W'(1);
            state_d = (&trig) ? S_PRESENT : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          for (int i = 0; i < N_CH; i++) begin
            if (trig[i] && !mask_q[i]) ts_d[i*TS_W +: TS_W] = cnt_q;
          end
          mask_d = new_mask;
          // A capture on the final window edge takes precedence over the timeout.
          if (&new_mask) begin
            timeout_d = 1'b0;
            state_d   = S_PRESENT;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            state_d   = S_PRESENT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PRESENT: begin
          if (ts_ready) begin
            hcnt_d  = '0;
            state_d = (HOLDOFF_CYC == 0) ? S_IDLE : S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          if (hcnt_q == HOLD_MAX) state_d = S_IDLE;
          else                    hcnt_d  = hcnt_q + 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ts_data  = ts_q;
  assign ch_mask  = mask_q;
  assign timeout  = timeout_q;
  assign ts_valid = ts_valid_q;
  assign busy     = busy_q;

endmodule
